tick_div_ctrl: RTL

- Synchronous, programmable clock-enable generator and controller for the design's slow-clock domain.
- Counts the single system clock and issues a one-cycle tick every DIV cycles, plus a square wave clk_out that toggles on each tick.
- Divide ratio is reconfigured at run time through a valid/ready handshake, with glitch-free application at a period boundary.
- Downstream logic stays on the system clock and qualifies with tick; no derived clocks are created.

---
 rtl/tick_div_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tick_div_ctrl.sv
// ============================================================================
// Module   : tick_div_ctrl
// Brief    : Programmable clock-enable generator with handshake-reconfigured
//            divide ratio, registered tick / square-wave outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_div_ctrl #(
    parameter int WIDTH       = 26,
    parameter int DEFAULT_DIV = 25000000
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             tick,
    output logic             clk_out,
    output logic             busy,
    output logic [7:0]       tick_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_default_div = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero        = '0;

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_div, w_div;
    logic [WIDTH-1:0] r_pend, w_pend;
    logic [WIDTH-1:0] r_cnt, w_cnt;
    logic             r_tick, w_tick;
    logic             r_clk_out, w_clk_out;
    logic             r_busy, w_busy;
    logic             r_cfg_ready, w_cfg_ready;
    logic [7:0]       r_tick_cnt, w_tick_cnt;

    logic             w_hs;
    logic             w_terminal;
    logic [WIDTH-1:0] w_cfg_clamped;

    assign w_hs          = cfg_valid & r_cfg_ready;
    // r_div is never 0, so div-1 cannot underflow even at the maximum ratio
    assign w_terminal    = (r_cnt == (r_div - c_one));
    assign w_cfg_clamped = (cfg_div == c_zero) ? c_one : cfg_div;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_div       <= c_default_div;
            r_pend      <= c_zero;
            r_cnt       <= c_zero;
            r_tick      <= 1'b0;
            r_clk_out   <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_tick_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state;
            r_div       <= w_div;
            r_pend      <= w_pend;
            r_cnt       <= w_cnt;
            r_tick      <= w_tick;
            r_clk_out   <= w_clk_out;
            r_busy      <= w_busy;
            r_cfg_ready <= w_cfg_ready;
            r_tick_cnt  <= w_tick_cnt;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_div      = r_div;
        w_pend     = r_pend;
        w_cnt      = r_cnt;
        w_tick     = 1'b0;
        w_clk_out  = r_clk_out;
        w_tick_cnt = r_tick_cnt;

        case (r_state)
            ST_IDLE: begin
                w_cnt = c_zero;
                if (w_hs) w_div = w_cfg_clamped;
                if (en) w_state = ST_RUN;
            end
            ST_RUN: begin
                if (!en) begin
                    // Stopping: a ratio offered now has no period to wait for
                    w_state = ST_IDLE;
                    w_cnt   = c_zero;
                    if (w_hs) w_div = w_cfg_clamped;
                end else begin
                    if (w_terminal) begin
                        w_cnt      = c_zero;
                        w_tick     = 1'b1;
                        w_clk_out  = ~r_clk_out;
                        w_tick_cnt = r_tick_cnt + 8'd1;
                    end else begin
                        w_cnt = r_cnt + c_one;
                    end
                    if (w_hs) begin
                        w_pend  = w_cfg_clamped;
                        w_state = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (!en) begin
                    w_state = ST_IDLE;
                    w_cnt   = c_zero;
                    w_div   = r_pend;
                end else if (w_terminal) begin
                    w_cnt      = c_zero;
                    w_tick     = 1'b1;
                    w_clk_out  = ~r_clk_out;
                    w_tick_cnt = r_tick_cnt + 8'd1;
                    w_div      = r_pend;
                    w_state    = ST_RUN;
                end else begin
                    w_cnt = r_cnt + c_one;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_cnt   = c_zero;
            end
        endcase

        w_busy      = (w_state != ST_IDLE);
        w_cfg_ready = (w_state != ST_PEND);
    end

    assign cfg_ready = r_cfg_ready;
    assign tick      = r_tick;
    assign clk_out   = r_clk_out;
    assign busy      = r_busy;
    assign tick_cnt  = r_tick_cnt;

endmodule

`default_nettype wire
